// File: rtl/sparse_window_feeder_if.sv
// Beat stream from the window feeder to the PE array.
// Master drives the beat fields and out_valid; slave drives out_ready.
//   out_valid/out_ready : handshake, transfer when both high
//   out_wei / out_act   : weight and activation of the beat
//   out_wei_idx         : kernel index k = r*K + c
//   out_col             : window base column
//   out_last_win        : last beat of a window
//   out_last_row        : last beat of the pass
//   out_zero            : marker beat for an all-zero kernel
interface sparse_window_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IF_WIDTH   = 16,
  parameter int unsigned K          = 3
);
  localparam int unsigned KK    = K * K;
  localparam int unsigned IDX_W = (KK > 1) ? $clog2(KK) : 1;
  localparam int unsigned COL_W = (IF_WIDTH > 1) ? $clog2(IF_WIDTH) : 1;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_wei;
  logic [DATA_WIDTH-1:0] out_act;
  logic [IDX_W-1:0]      out_wei_idx;
  logic [COL_W-1:0]      out_col;
  logic                  out_last_win;
  logic                  out_last_row;
  logic                  out_zero;

  modport master (
    output out_valid, out_wei, out_act, out_wei_idx, out_col,
           out_last_win, out_last_row, out_zero,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_wei, out_act, out_wei_idx, out_col,
           out_last_win, out_last_row, out_zero,
    output out_ready
  );
endinterface

// File: rtl/sparse_window_feeder.sv
// Sliding-window feeder for the PE array. Keeps a K-row circular activation
// buffer and a flag-compressed KxK weight store, and per pass streams one
// (weight, activation) beat per cycle over every window, skipping zero
// weights in sparse mode.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   i_mode                : 0 dense, 1 sparse
//   i_start               : begin a row pass (needs K rows loaded, IDLE)
//   i_wei_flag_wr/_data   : load nonzero-weight flag, rewinds weight pointer
//   i_wei_wr/_data        : write next weight slot
//   i_act_wr/_data        : push one activation row
//   o_out                 : beat stream (master side)
//   o_busy, o_row_done    : pass in progress, one-cycle pass-complete pulse
//   o_rows_valid          : loaded rows, saturating at K
//   o_err                 : sticky protocol error
module sparse_window_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IF_WIDTH   = 16,
  parameter int unsigned K          = 3,
  parameter int unsigned STRIDE     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_mode,
  input  logic                           i_start,
  input  logic                           i_wei_flag_wr,
  input  logic [K*K-1:0]                 i_wei_flag_data,
  input  logic                           i_wei_wr,
  input  logic [DATA_WIDTH-1:0]          i_wei_wr_data,
  input  logic                           i_act_wr,
  input  logic [IF_WIDTH*DATA_WIDTH-1:0] i_act_wr_data,
  sparse_window_feeder_if.master         o_out,
  output logic                           o_busy,
  output logic                           o_row_done,
  output logic [$clog2(K):0]             o_rows_valid,
  output logic                           o_err
);
  localparam int unsigned KK     = K * K;
  localparam int unsigned IDX_W  = (KK > 1) ? $clog2(KK) : 1;
  localparam int unsigned COL_W  = (IF_WIDTH > 1) ? $clog2(IF_WIDTH) : 1;
  localparam int unsigned RV_W   = $clog2(K) + 1;
  localparam int unsigned PTR_W  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned WP_W   = $clog2(KK + 1);
  localparam int unsigned ROW_W  = IF_WIDTH * DATA_WIDTH;
  localparam int unsigned BIT_W  = $clog2(ROW_W);
  localparam int unsigned NW     = (IF_WIDTH - K) / STRIDE + 1;
  localparam int unsigned LAST_W = (NW - 1) * STRIDE;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Lowest set flag bit at or above 'from' (0 if none).
  function automatic logic [IDX_W-1:0] next_set(input logic [KK-1:0] f, input int from);
    next_set = '0;
    for (int i = int'(KK) - 1; i >= 0; i--) begin
      if (f[i] && (i >= from)) next_set = IDX_W'(i);
    end
  endfunction

  // Whether any flag bit at or above 'from' is set.
  function automatic logic has_set(input logic [KK-1:0] f, input int from);
    has_set = 1'b0;
    for (int i = 0; i < int'(KK); i++) begin
      if (f[i] && (i >= from)) has_set = 1'b1;
    end
  endfunction

  // Storage
  logic [KK-1:0]         r_flag;
  logic [DATA_WIDTH-1:0] r_wei [KK];
  logic [WP_W-1:0]       r_wptr;
  logic [ROW_W-1:0]      r_act [K];
  logic [PTR_W-1:0]      r_oldest;
  logic [RV_W-1:0]       r_rows_valid;
  logic                  r_err;

  // FSM and registered beat
  state_t                r_state, w_state_d;
  logic                  r_mode;
  logic                  r_busy, r_row_done;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_wei_o, r_act_o;
  logic [IDX_W-1:0]      r_idx;
  logic [COL_W-1:0]      r_col;
  logic                  r_last_win, r_last_row, r_zero;

  // Combinational helpers
  logic                  w_idle, w_full, w_mode, w_zero_kern, w_start_ok;
  logic [IDX_W-1:0]      w_first_k, w_next_k;
  logic                  w_load, w_valid_d;
  logic [COL_W-1:0]      w_sel_w;
  logic [IDX_W-1:0]      w_sel_k;
  logic                  w_sel_last_win, w_sel_last_row;
  logic [DATA_WIDTH-1:0] w_sel_wei, w_sel_act;
  logic [PTR_W-1:0]      w_rd_phys;
  logic [BIT_W-1:0]      w_rd_bit;
  logic [ROW_W-1:0]      w_rd_row;
  logic [IDX_W-1:0]      w_wslot;
  logic                  w_wslot_ok, w_wei_we, w_wr_err;
  logic [PTR_W-1:0]      w_wr_phys;

  assign w_idle      = (r_state == S_IDLE);
  assign w_full      = (r_rows_valid == RV_W'(K));
  // Mode is sampled live until start, then frozen for the pass.
  assign w_mode      = w_idle ? i_mode : r_mode;
  assign w_zero_kern = w_mode && (r_flag == '0);
  assign w_start_ok  = w_idle && i_start && w_full;
  assign w_first_k   = (w_mode && !w_zero_kern) ? next_set(r_flag, 0) : '0;
  assign w_next_k    = w_mode ? next_set(r_flag, int'(r_idx) + 1) : (r_idx + IDX_W'(1));

  // Next state and selection of the next beat to load
  always_comb begin
    w_state_d = r_state;
    w_valid_d = r_valid;
    w_load    = 1'b0;
    w_sel_w   = '0;
    w_sel_k   = '0;
    unique case (r_state)
      S_IDLE: begin
        w_valid_d = 1'b0;
        if (w_start_ok) begin
          w_state_d = S_RUN;
          w_valid_d = 1'b1;
          w_load    = 1'b1;
          w_sel_k   = w_first_k;
        end
      end
      S_RUN: begin
        if (r_valid && o_out.out_ready) begin
          if (r_last_row) begin
            w_state_d = S_DONE;
            w_valid_d = 1'b0;
          end else begin
            w_load = 1'b1;
            if (r_last_win) begin
              w_sel_w = r_col + COL_W'(STRIDE);
              w_sel_k = w_first_k;
            end else begin
              w_sel_w = r_col;
              w_sel_k = w_next_k;
            end
          end
        end
      end
      S_DONE: begin
        w_state_d = S_IDLE;
        w_valid_d = 1'b0;
      end
      default: begin
        w_state_d = S_IDLE;
        w_valid_d = 1'b0;
      end
    endcase
  end

  // Beat fields for the selected (window, k)
  always_comb begin
    w_sel_last_win = w_zero_kern ||
                     (w_mode ? !has_set(r_flag, int'(w_sel_k) + 1)
                             : (w_sel_k == IDX_W'(KK - 1)));
    w_sel_last_row = w_sel_last_win && (w_sel_w == COL_W'(LAST_W));
    // Logical row k/K lives at physical (oldest + k/K) mod K.
    w_rd_phys = PTR_W'((int'(r_oldest) + int'(w_sel_k) / int'(K)) % int'(K));
    w_rd_bit  = BIT_W'((int'(w_sel_w) + int'(w_sel_k) % int'(K)) * int'(DATA_WIDTH));
    w_rd_row  = r_act[w_rd_phys];
    w_sel_act = w_zero_kern ? '0 : w_rd_row[w_rd_bit +: DATA_WIDTH];
    w_sel_wei = w_zero_kern ? '0 : r_wei[w_sel_k];
  end

  // State and output beat registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_busy     <= 1'b0;
      r_row_done <= 1'b0;
      r_valid    <= 1'b0;
      r_wei_o    <= '0;
      r_act_o    <= '0;
      r_idx      <= '0;
      r_col      <= '0;
      r_last_win <= 1'b0;
      r_last_row <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_busy     <= (w_state_d != S_IDLE);
      r_row_done <= (w_state_d == S_DONE);
      r_valid    <= w_valid_d;
      if (w_start_ok) r_mode <= i_mode;
      if (w_load) begin
        r_wei_o    <= w_sel_wei;
        r_act_o    <= w_sel_act;
        r_idx      <= w_sel_k;
        r_col      <= w_sel_w;
        r_last_win <= w_sel_last_win;
        r_last_row <= w_sel_last_row;
        r_zero     <= w_zero_kern;
      end
    end
  end

  // Weight slot: sparse mode skips to the next flagged slot, dense is sequential.
  assign w_wslot    = i_mode ? next_set(r_flag, int'(r_wptr)) : IDX_W'(r_wptr);
  assign w_wslot_ok = i_mode ? has_set(r_flag, int'(r_wptr)) : (r_wptr < WP_W'(KK));
  assign w_wei_we   = w_idle && !i_wei_flag_wr && i_wei_wr && w_wslot_ok;
  assign w_wr_phys  = w_full ? r_oldest
                             : PTR_W'((int'(r_oldest) + int'(r_rows_valid)) % int'(K));
  assign w_wr_err   = (!w_idle && (i_wei_flag_wr || i_wei_wr || i_act_wr)) ||
                      (w_idle && !i_wei_flag_wr && i_wei_wr && !w_wslot_ok);

  // Store pointers, row count and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag       <= '0;
      r_wptr       <= '0;
      r_oldest     <= '0;
      r_rows_valid <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_wr_err) r_err <= 1'b1;
      if (w_idle) begin
        if (i_wei_flag_wr) begin
          r_flag <= i_wei_flag_data;
          r_wptr <= '0;
        end else if (w_wei_we) begin
          r_wptr <= WP_W'(w_wslot) + WP_W'(1);
        end
        if (i_act_wr) begin
          if (w_full) r_oldest <= PTR_W'((int'(r_oldest) + 1) % int'(K));
          else        r_rows_valid <= r_rows_valid + RV_W'(1);
        end
      end
    end
  end

  // Weight and activation arrays (contents need no reset)
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_wei_we) r_wei[w_wslot] <= i_wei_wr_data;
      if (w_idle && i_act_wr) r_act[w_wr_phys] <= i_act_wr_data;
    end
  end

  assign o_out.out_valid    = r_valid;
  assign o_out.out_wei      = r_wei_o;
  assign o_out.out_act      = r_act_o;
  assign o_out.out_wei_idx  = r_idx;
  assign o_out.out_col      = r_col;
  assign o_out.out_last_win = r_last_win;
  assign o_out.out_last_row = r_last_row;
  assign o_out.out_zero     = r_zero;
  assign o_busy             = r_busy;
  assign o_row_done         = r_row_done;
  assign o_rows_valid       = r_rows_valid;
  assign o_err              = r_err;
endmodule

// File: tb/tb_sparse_window_feeder.sv
// Randomised bench for sparse_window_feeder with a queue-based beat model.
module tb_sparse_window_feeder;
  localparam int DW = 8, IFW = 16, KP = 3, KKP = 9, NWIN = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, i_mode, i_start, i_wei_flag_wr, i_wei_wr, i_act_wr;
  logic [KKP-1:0] i_wei_flag_data;
  logic [DW-1:0]  i_wei_wr_data;
  logic [IFW*DW-1:0] i_act_wr_data;
  logic           o_busy, o_row_done, o_err;
  logic [2:0]     o_rows_valid;

  sparse_window_feeder_if #(.DATA_WIDTH(DW), .IF_WIDTH(IFW), .K(KP)) s_if ();

  sparse_window_feeder #(.DATA_WIDTH(DW), .IF_WIDTH(IFW), .K(KP), .STRIDE(1)) dut (
    .clk(clk), .reset(reset), .i_mode(i_mode), .i_start(i_start),
    .i_wei_flag_wr(i_wei_flag_wr), .i_wei_flag_data(i_wei_flag_data),
    .i_wei_wr(i_wei_wr), .i_wei_wr_data(i_wei_wr_data),
    .i_act_wr(i_act_wr), .i_act_wr_data(i_act_wr_data),
    .o_out(s_if.master), .o_busy(o_busy), .o_row_done(o_row_done),
    .o_rows_valid(o_rows_valid), .o_err(o_err)
  );

  typedef struct {int wei; int act; int idx; int col; int lw; int lr; int z;} beat_t;

  int n_vec = 0, n_err = 0;
  int m_rows[3][IFW];
  int m_nrows;
  int m_wei[KKP];
  logic [KKP-1:0] m_flag;
  int m_wcnt;
  beat_t exp_q[$];
  beat_t log_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  function automatic logic [63:0] pk(input beat_t b);
    return {8'h0, 8'(b.wei), 8'(b.act), 8'(b.idx), 8'(b.col), 8'(b.lw), 8'(b.lr), 8'(b.z)};
  endfunction

  function automatic beat_t mk(input int wei, input int act, input int idx, input int col,
                               input int lw, input int lr, input int z);
    beat_t b;
    b.wei = wei; b.act = act; b.idx = idx; b.col = col; b.lw = lw; b.lr = lr; b.z = z;
    return b;
  endfunction

  function automatic beat_t cur_beat();
    return mk(int'(s_if.out_wei), int'(s_if.out_act), int'(s_if.out_wei_idx),
              int'(s_if.out_col), int'(s_if.out_last_win), int'(s_if.out_last_row),
              int'(s_if.out_zero));
  endfunction

  // Expected beat list of a whole pass, straight from the enumeration rules.
  task automatic build_expected(input bit mode);
    exp_q.delete();
    for (int w = 0; w < NWIN; w++) begin
      int ks[$];
      for (int k = 0; k < KKP; k++) if (!mode || m_flag[k]) ks.push_back(k);
      if (ks.size() == 0) exp_q.push_back(mk(0, 0, 0, w, 1, int'(w == NWIN - 1), 1));
      else begin
        for (int i = 0; i < ks.size(); i++) begin
          int k;
          int lw;
          k  = ks[i];
          lw = int'(i == ks.size() - 1);
          exp_q.push_back(mk(m_wei[k], m_rows[k / KP][w + k % KP], k, w, lw,
                             int'(lw == 1 && w == NWIN - 1), 0));
        end
      end
    end
  endtask

  // Per-cycle checker: handshaken beats against the model, stalls hold still.
  logic [63:0] held;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin : compare
    beat_t b;
    b = cur_beat();
    if (prev_stall) begin
      chk("stall_valid", 64'(s_if.out_valid), 64'(1));
      chk("stall_hold", pk(b), held);
    end
    if (s_if.out_valid && s_if.out_ready) begin
      log_q.push_back(b);
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_beat: got col %0d idx %0d, required no beat", b.col, b.idx);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk($sformatf("beat%0d", log_q.size() - 1), pk(b), pk(e));
      end
    end
    prev_stall = s_if.out_valid && !s_if.out_ready;
    held = pk(b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_nrows = 0; m_flag = '0; m_wcnt = 0;
    exp_q.delete();
  endtask

  task automatic wr_flag(input logic [KKP-1:0] f);
    i_wei_flag_wr = 1'b1; i_wei_flag_data = f;
    tick();
    i_wei_flag_wr = 1'b0;
    m_flag = f; m_wcnt = 0;
  endtask

  task automatic wr_wei(input int v);
    int slots[$];
    i_wei_wr = 1'b1; i_wei_wr_data = DW'(v);
    tick();
    i_wei_wr = 1'b0;
    for (int k = 0; k < KKP; k++) if (!i_mode || m_flag[k]) slots.push_back(k);
    if (m_wcnt < slots.size()) m_wei[slots[m_wcnt]] = v & 8'hFF;
    m_wcnt++;
  endtask

  task automatic wr_act(input int row[IFW]);
    for (int c = 0; c < IFW; c++) i_act_wr_data[c*DW +: DW] = DW'(row[c]);
    i_act_wr = 1'b1;
    tick();
    i_act_wr = 1'b0;
    if (m_nrows < KP) begin
      m_rows[m_nrows] = row;
      m_nrows++;
    end else begin
      m_rows[0] = m_rows[1];
      m_rows[1] = m_rows[2];
      m_rows[2] = row;
    end
  endtask

  task automatic load_std_row(input int r);
    int row[IFW];
    for (int c = 0; c < IFW; c++) row[c] = 16 * r + c;
    wr_act(row);
  endtask

  function automatic logic pat_val(input int pat, input int n);
    if (pat == 0) return 1'b1;
    if (pat == 1) return ((n % 4) == 0) || ((n % 4) == 3);
    return 1'($urandom % 2);
  endfunction

  // One full pass; returns cycles from start acceptance to row_done.
  task automatic run_pass(input int pat, input bit inject, output int cycles);
    int n;
    int nexp;
    bit busy_ok;
    build_expected(i_mode);
    log_q.delete();
    nexp = exp_q.size();
    i_start = 1'b1;
    s_if.out_ready = pat_val(pat, 0);
    tick();
    i_start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!o_row_done && n < 3000) begin
      busy_ok &= o_busy;
      s_if.out_ready = pat_val(pat, n);
      if (inject && n == 5) begin
        i_act_wr_data = '1;
        i_act_wr = 1'b1;
      end
      tick();
      i_act_wr = 1'b0;
      n++;
    end
    chk("row_done_seen", 64'(o_row_done), 64'(1));
    chk("busy_in_pass", 64'(busy_ok & o_busy), 64'(1));
    chk("beat_count", 64'(log_q.size()), 64'(nexp));
    chk("exp_drained", 64'(exp_q.size()), 64'(0));
    cycles = n;
    s_if.out_ready = 1'b1;
    tick();
    chk("busy_after", 64'(o_busy), 64'(0));
    chk("row_done_pulse", 64'(o_row_done), 64'(0));
  endtask

  initial begin : main
    int cyc;
    reset = 1'b1; i_mode = 1'b0; i_start = 1'b0;
    i_wei_flag_wr = 1'b0; i_wei_flag_data = '0; i_wei_wr = 1'b0; i_wei_wr_data = '0;
    i_act_wr = 1'b0; i_act_wr_data = '0; s_if.out_ready = 1'b1;
    tick();
    do_reset();
    chk("rst_valid", 64'(s_if.out_valid), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_rows", 64'(o_rows_valid), 64'(0));
    chk("rst_err", 64'(o_err), 64'(0));
    chk("rst_done", 64'(o_row_done), 64'(0));

    // start with only two rows is ignored
    load_std_row(0);
    load_std_row(1);
    chk("rows_two", 64'(o_rows_valid), 64'(2));
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("early_start_busy", 64'(o_busy), 64'(0));
    chk("early_start_valid", 64'(s_if.out_valid), 64'(0));
    tick();
    chk("early_start_valid2", 64'(s_if.out_valid), 64'(0));
    chk("early_start_err", 64'(o_err), 64'(0));
    load_std_row(2);
    chk("rows_three", 64'(o_rows_valid), 64'(3));

    // dense
    i_mode = 1'b0;
    wr_flag('1);
    for (int v = 1; v <= 9; v++) wr_wei(v);
    run_pass(0, 1'b0, cyc);
    chk("dense_cycles", 64'(cyc), 64'(127));
    chk("dense_first", pk(log_q[0]), pk(mk(1, 0, 0, 0, 0, 0, 0)));
    chk("dense_9th", pk(log_q[8]), pk(mk(9, 34, 8, 0, 1, 0, 0)));
    chk("dense_last", pk(log_q[125]), pk(mk(9, 47, 8, 13, 1, 1, 0)));

    // sparse
    i_mode = 1'b1;
    wr_flag(9'b100010001);
    wr_wei(5); wr_wei(6); wr_wei(7);
    run_pass(0, 1'b0, cyc);
    chk("sparse_cycles", 64'(cyc), 64'(43));
    chk("sparse_b1", pk(log_q[1]), pk(mk(6, 17, 4, 0, 0, 0, 0)));
    chk("sparse_last", pk(log_q[41]), pk(mk(7, 47, 8, 13, 1, 1, 0)));

    // sparse with backpressure 1,0,0,1
    run_pass(1, 1'b0, cyc);
    chk("bp_count", 64'(log_q.size()), 64'(42));

    // zero kernel
    wr_flag('0);
    run_pass(0, 1'b0, cyc);
    chk("zero_cycles", 64'(cyc), 64'(15));
    chk("zero_first", pk(log_q[0]), pk(mk(0, 0, 0, 0, 1, 0, 1)));
    chk("zero_last", pk(log_q[13]), pk(mk(0, 0, 0, 13, 1, 1, 1)));

    // sliding window
    begin
      int row[IFW];
      for (int c = 0; c < IFW; c++) row[c] = 100 + c;
      wr_act(row);
    end
    chk("slide_rows", 64'(o_rows_valid), 64'(3));
    i_mode = 1'b0;
    wr_flag('1);
    for (int v = 1; v <= 9; v++) wr_wei(v);
    run_pass(0, 1'b0, cyc);
    chk("slide_b0", pk(log_q[0]), pk(mk(1, 16, 0, 0, 0, 0, 0)));
    chk("slide_b6", pk(log_q[6]), pk(mk(7, 100, 6, 0, 0, 0, 0)));
    chk("slide_b8", pk(log_q[8]), pk(mk(9, 102, 8, 0, 1, 0, 0)));

    // act_wr during RUN: flagged, buffer untouched (model keeps old rows)
    chk("err_before", 64'(o_err), 64'(0));
    run_pass(0, 1'b1, cyc);
    chk("err_run_wr", 64'(o_err), 64'(1));
    chk("err_rows", 64'(o_rows_valid), 64'(3));

    // randomised passes
    for (int it = 0; it < 6; it++) begin
      int row[IFW];
      int nw;
      logic [KKP-1:0] f;
      i_mode = 1'($urandom % 2);
      f = (it == 2) ? '0 : KKP'($urandom);
      wr_flag(f);
      nw = i_mode ? $countones(f) : KKP;
      for (int j = 0; j < nw; j++) wr_wei(int'($urandom_range(1, 255)));
      for (int c = 0; c < IFW; c++) row[c] = int'($urandom_range(0, 255));
      wr_act(row);
      chk("rnd_rows", 64'(o_rows_valid), 64'(3));
      run_pass(int'($urandom % 3), 1'b0, cyc);
    end

    // reset in the middle of a pass
    do_reset();
    load_std_row(0); load_std_row(1); load_std_row(2);
    i_mode = 1'b0;
    wr_flag('1);
    for (int v = 1; v <= 9; v++) wr_wei(v);
    build_expected(1'b0);
    log_q.delete();
    s_if.out_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int n = 0; n < 500 && log_q.size() < 10; n++) tick();
    chk("mid_beats", 64'(log_q.size() >= 10), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_nrows = 0; m_flag = '0; m_wcnt = 0;
    chk("mid_rst_valid", 64'(s_if.out_valid), 64'(0));
    chk("mid_rst_busy", 64'(o_busy), 64'(0));
    chk("mid_rst_rows", 64'(o_rows_valid), 64'(0));
    chk("mid_rst_err", 64'(o_err), 64'(0));

    // weight write with no free slot
    i_mode = 1'b1;
    wr_flag('0);
    wr_wei(5);
    chk("overflow_err", 64'(o_err), 64'(1));

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
